// File: rtl/quad_pkg.sv
// quad_pkg: shared count width, quadrature phase encodings and step decode helper.
package quad_pkg;
  localparam int CNT_W_DEF = 18;
  localparam logic [1:0] PH_00 = 2'b00, PH_10 = 2'b10, PH_11 = 2'b11, PH_01 = 2'b01;
  // Returns {valid, up, err}; a double-bit change is illegal and never counts.
  function automatic logic [2:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] up_nxt;
    up_nxt = prev == PH_00 ? PH_10 : prev == PH_10 ? PH_11 : prev == PH_11 ? PH_01 : PH_00;
    if (cur == prev) return 3'b000;
    if ((cur ^ prev) == PH_11) return 3'b001;
    return {1'b1, cur == up_nxt, 1'b0};
  endfunction
endpackage

// File: rtl/quad_input_filter.sv
// quad_input_filter: 2-flop synchroniser plus FILT_LEN-cycle persistence filter for one raw input.
module quad_input_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);
  logic [1:0] sync;
  logic [3:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) cnt <= '0;
      else if (cnt == 4'(FILT_LEN - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else cnt <= cnt + 4'd1;
    end
endmodule

// File: rtl/quad_encoder_counter.sv
// quad_encoder_counter: x4 quadrature decoder with up/down position count and sticky error.
// Define QUAD_INDEX_EN to build the index-pulse position latch.
module quad_encoder_counter
  import quad_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int FILT_LEN = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             A,
  input  logic             B,
  input  logic             Idx,
  input  logic             Load,
  input  logic [CNT_W-1:0] LoadVal,
  input  logic             Clr,
  input  logic             ErrClr,
  output logic [CNT_W-1:0] Enc,
  output logic             Dir,
  output logic             Step,
  output logic             Err,
  output logic [CNT_W-1:0] IdxPos,
  output logic             IdxSeen
);
  logic       a_f, b_f;
  logic [1:0] prev;
  logic [2:0] qs;
  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_fa (.clk(Clk), .rst(Rst), .raw(A), .filt(a_f));
  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_fb (.clk(Clk), .rst(Rst), .raw(B), .filt(b_f));
  assign qs = quad_step(prev, {a_f, b_f});
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      prev <= PH_00;
      Enc  <= '0;
      Dir  <= 1'b0;
      Step <= 1'b0;
      Err  <= 1'b0;
    end else begin
      prev <= {a_f, b_f};
      Step <= 1'b0;
      if (Load) Enc <= LoadVal;
      else if (Clr) Enc <= '0;
      else if (qs[2]) begin
        Enc  <= qs[1] ? Enc + CNT_W'(1) : Enc - CNT_W'(1);
        Dir  <= qs[1];
        Step <= 1'b1;
      end
      if (qs[0]) Err <= 1'b1;
      else if (ErrClr) Err <= 1'b0;
    end
`ifdef QUAD_INDEX_EN
  logic idx_f, idx_prev;
  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_fi (.clk(Clk), .rst(Rst), .raw(Idx), .filt(idx_f));
  // Enc here is the pre-step value registered before this cycle's update.
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      idx_prev <= 1'b0;
      IdxPos   <= '0;
      IdxSeen  <= 1'b0;
    end else begin
      idx_prev <= idx_f;
      if (idx_f && !idx_prev) begin
        IdxPos  <= Enc;
        IdxSeen <= 1'b1;
      end
    end
`else
  logic idx_unused;
  assign idx_unused = Idx;
  assign IdxPos     = '0;
  assign IdxSeen    = 1'b0;
`endif
endmodule

// File: tb/tb_quad_encoder_counter.sv
// tb_quad_encoder_counter: scoreboard bench; stimulus queues expected {Enc,Dir} per step, monitor checks on Step.
module tb_quad_encoder_counter;
  logic        Clk = 1'b0, Rst = 1'b1, A = 1'b0, B = 1'b0, Idx = 1'b0;
  logic        Load = 1'b0, Clr = 1'b0, ErrClr = 1'b0;
  logic [17:0] LoadVal = '0;
  logic [17:0] Enc, IdxPos;
  logic        Dir, Step, Err, IdxSeen;

  quad_encoder_counter dut (
    .Clk(Clk), .Rst(Rst), .A(A), .B(B), .Idx(Idx), .Load(Load), .LoadVal(LoadVal),
    .Clr(Clr), .ErrClr(ErrClr), .Enc(Enc), .Dir(Dir), .Step(Step), .Err(Err),
    .IdxPos(IdxPos), .IdxSeen(IdxSeen)
  );

  always #5 Clk = ~Clk;

  typedef struct {logic [17:0] enc; logic dir;} exp_t;
  exp_t        q[$];
  int          errors = 0, checks = 0, nsteps = 0;
  logic [17:0] exp_enc = '0;
  logic        exp_dir = 1'b0;
  logic [1:0]  ph_tbl[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int          ph = 0;

  always @(negedge Clk) begin
    exp_t e;
    if (!Rst && Step) begin
      checks++;
      nsteps++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step enc=%h dir=%b", Enc, Dir);
      end else begin
        e = q.pop_front();
        if (Enc !== e.enc || Dir !== e.dir) begin
          errors++;
          $display("FAIL step enc=%h dir=%b expected enc=%h dir=%b", Enc, Dir, e.enc, e.dir);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic mv(input bit up, input int hold, input bit expect_step = 1'b1);
    ph = up ? (ph + 1) % 4 : (ph + 3) % 4;
    {A, B} = ph_tbl[ph];
    if (expect_step) begin
      exp_enc = up ? exp_enc + 18'd1 : exp_enc - 18'd1;
      exp_dir = up;
      q.push_back('{exp_enc, exp_dir});
    end
    tick(hold);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_enc"}, Enc, 0);
    chk({tag, "_dir"}, Dir, 0);
    chk({tag, "_step"}, Step, 0);
    chk({tag, "_err"}, Err, 0);
    chk({tag, "_idxpos"}, IdxPos, 0);
    chk({tag, "_idxseen"}, IdxSeen, 0);
  endtask

  initial begin
    logic [17:0] old;
    int n0;
    tick(2);
    chk_zero("reset");
    Rst = 1'b0;
    tick(2);
    // 1: eight up cycles then eight down cycles
    n0 = nsteps;
    repeat (32) mv(1'b1, 20);
    chk("up_enc", Enc, 32);
    chk("up_dir", Dir, 1);
    chk("up_steps", nsteps - n0, 32);
    chk("up_drain", q.size(), 0);
    repeat (32) mv(1'b0, 20);
    chk("dn_enc", Enc, 0);
    chk("dn_dir", Dir, 0);
    // 2: glitches and latency
    A = 1'b1; tick(2); A = 1'b0; tick(20);
    chk("glitch2_enc", Enc, 0);
    mv(1'b1, 3);
    mv(1'b0, 20);
    chk("glitch3_drain", q.size(), 0);
    chk("glitch3_enc", Enc, 0);
    old = exp_enc;
    mv(1'b1, 5);
    chk("lat5", Enc, old);
    tick(1);
    chk("lat6", Enc, exp_enc);
    tick(20);
    // 3: load wrap and clear priority
    LoadVal = 18'h1FFFF; Load = 1'b1; tick(1); Load = 1'b0;
    exp_enc = 18'h1FFFF;
    chk("load1", Enc, 18'h1FFFF);
    mv(1'b1, 20);
    chk("wrap_pos", Enc, 18'h20000);
    LoadVal = 18'h3FFFF; Load = 1'b1; tick(1); Load = 1'b0;
    exp_enc = 18'h3FFFF;
    mv(1'b1, 20);
    chk("wrap_all", Enc, 0);
    mv(1'b1, 5, 1'b0);
    Clr = 1'b1; tick(1); Clr = 1'b0;
    exp_enc = '0;
    chk("clr_enc", Enc, 0);
    chk("clr_step", Step, 0);
    tick(20);
    chk("clr_after", Enc, 0);
    // 4: illegal transitions and sticky error
    ph = (ph + 2) % 4; {A, B} = ph_tbl[ph]; tick(20);
    chk("ill_err", Err, 1);
    chk("ill_enc", Enc, exp_enc);
    chk("ill_dir", Dir, exp_dir);
    ErrClr = 1'b1; tick(1); ErrClr = 1'b0;
    chk("errclr", Err, 0);
    ph = (ph + 2) % 4; {A, B} = ph_tbl[ph]; tick(5);
    ErrClr = 1'b1; tick(1); ErrClr = 1'b0;
    chk("ill_clr_same", Err, 1);
    tick(5);
    chk("ill_sticky", Err, 1);
    ErrClr = 1'b1; tick(1); ErrClr = 1'b0;
    chk("errclr2", Err, 0);
    // 5: index latch
    LoadVal = 18'd96; Load = 1'b1; tick(1); Load = 1'b0;
    exp_enc = 18'd96;
    repeat (4) mv(1'b1, 10);
    chk("cnt100", Enc, 100);
    Idx = 1'b1; tick(10); Idx = 1'b0; tick(10);
`ifdef QUAD_INDEX_EN
    chk("idxpos", IdxPos, 100);
    chk("idxseen", IdxSeen, 1);
`else
    chk("idxpos", IdxPos, 0);
    chk("idxseen", IdxSeen, 0);
`endif
    // 6: async reset mid-motion
    while (ph != 0) mv(1'b1, 10);
    chk("pre_rst_drain", q.size(), 0);
    mv(1'b1, 2, 1'b0);
    #2 Rst = 1'b1;
    #1 chk_zero("midrst");
    q.delete();
    tick(3);
    Rst = 1'b0;
    exp_enc = 18'd1;
    exp_dir = 1'b1;
    q.push_back('{exp_enc, exp_dir});
    tick(20);
    repeat (3) mv(1'b1, 20);
    chk("resume_enc", Enc, 4);
    chk("resume_err", Err, 0);
    chk("resume_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
